// File: rtl/ycbcr_stream_ctrl.sv
// Frame-level gate in front of the RGB->YCbCr converter: admits whole frames only,
// reports completion after the converter latency and checks frame geometry.
module ycbcr_stream_ctrl #(
   parameter logic [11:0] IMG_HDISP = 12'd640,
   parameter logic [11:0] IMG_VDISP = 12'd480,
   parameter logic [3:0]  LATENCY   = 4'd3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_enable,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   output logic        conv_frame_vsync,
   output logic        conv_frame_href,
   output logic        conv_frame_clken,
   output logic        busy,
   output logic        frame_start,
   output logic        frame_done,
   output logic        frame_drop,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic [1:0]  err_flags,
   output logic [7:0]  frame_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   state_t      state_q, state_d;
   logic        vs_d_q, vs_d_d;
   logic        href_d_q, href_d_d;
   logic [3:0]  drain_q, drain_d;
   logic [11:0] pix_x_q, pix_x_d;
   logic [11:0] pix_y_q, pix_y_d;
   logic [1:0]  err_acc_q, err_acc_d;
   logic [1:0]  err_flags_q, err_flags_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;

   logic        vs_rise, vs_fall;
   logic        in_active, admit, drain_zero;
   logic        pix_acc, line_end;
   logic [11:0] x_cnt, y_cnt;

   // Edge detection and per-cycle events
   always_comb begin
      vs_rise    = per_frame_vsync & ~vs_d_q;
      vs_fall    = ~per_frame_vsync & vs_d_q;
      in_active  = (state_q == ST_ACTIVE);
      admit      = (state_q == ST_WAIT) & vs_rise & cfg_enable;
      drain_zero = (state_q == ST_DRAIN) & (drain_q == 4'd0);
      pix_acc    = in_active & per_frame_href & per_frame_clken;
      // A coincident href fall and vsync fall collapse into a single line end.
      line_end   = in_active & href_d_q & (~per_frame_href | vs_fall);
      x_cnt      = pix_acc ? sat_inc(pix_x_q) : pix_x_q;
      y_cnt      = line_end ? sat_inc(pix_y_q) : pix_y_q;
   end

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      vs_d_d      = per_frame_vsync;
      href_d_d    = per_frame_href;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      err_acc_d   = err_acc_q;
      err_flags_d = err_flags_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_enable) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (admit)            state_d = ST_ACTIVE;
            else if (!cfg_enable) state_d = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (vs_fall) begin
               state_d = ST_DRAIN;
               drain_d = LATENCY - 4'd1;
            end
         end
         ST_DRAIN: begin
            if (drain_zero) state_d = cfg_enable ? ST_WAIT : ST_IDLE;
            else            drain_d = drain_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (admit) begin
         pix_x_d   = 12'd0;
         pix_y_d   = 12'd0;
         err_acc_d = 2'b00;
      end else if (in_active) begin
         pix_x_d = line_end ? 12'd0 : x_cnt;
         pix_y_d = y_cnt;
         if (line_end && (x_cnt != IMG_HDISP)) err_acc_d[0] = 1'b1;
         if (vs_fall && (y_cnt != IMG_VDISP))  err_acc_d[1] = 1'b1;
      end

      if (drain_zero) begin
         err_flags_d = err_acc_q;
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         drain_q     <= 4'd0;
         vs_d_q      <= 1'b0;
         href_d_q    <= 1'b0;
         pix_x_q     <= 12'd0;
         pix_y_q     <= 12'd0;
         err_acc_q   <= 2'b00;
         err_flags_q <= 2'b00;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         vs_d_q      <= vs_d_d;
         href_d_q    <= href_d_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         err_acc_q   <= err_acc_d;
         err_flags_q <= err_flags_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Gating is combinational so admitted frames see no added latency; the
   // completion status is visible in the same cycle as frame_done.
   always_comb begin
      conv_frame_vsync = (in_active | admit) & per_frame_vsync;
      conv_frame_href  = (in_active | admit) & per_frame_href;
      conv_frame_clken = (in_active | admit) & per_frame_clken;
      busy             = in_active | (state_q == ST_DRAIN);
      frame_start      = admit;
      frame_done       = drain_zero;
      frame_drop       = (state_q == ST_DRAIN) & vs_rise;
      pix_x            = pix_x_q;
      pix_y            = pix_y_q;
      err_flags        = err_flags_d;
      frame_cnt        = frame_cnt_d;
   end

endmodule

// File: doc/ycbcr_stream_ctrl.md
# ycbcr_stream_ctrl

Frame-level sequencer that sits in front of the 3-stage RGB888→YCbCr444 converter in the sobel_edge video chain. It gates the sensor's vsync, href and clken into the converter so that only whole frames enter. Enable changes take effect only at frame boundaries. After the converter's pipeline latency it signals frame completion, and it checks each frame's geometry against IMG_HDISP/IMG_VDISP.

## Interface
- IMG_HDISP, 12'd640, expected accepted pixels per line
- IMG_VDISP, 12'd480, expected lines per frame
- LATENCY, 4'd3, converter pipeline depth in clk cycles (legal 1..15)
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_enable  in  1  request processing; sampled only at frame boundaries
- per_frame_vsync  in  1  sensor vsync, active-high for the whole frame
- per_frame_href  in  1  sensor line valid
- per_frame_clken  in  1  sensor pixel strobe
- conv_frame_vsync  out  1  gated vsync to converter
- conv_frame_href  out  1  gated href to converter
- conv_frame_clken  out  1  gated clken to converter
- busy  out  1  state is ACTIVE or DRAIN
- frame_start  out  1  one-cycle pulse when a frame is admitted
- frame_done  out  1  one-cycle pulse when the last converted pixel has left the converter
- frame_drop  out  1  one-cycle pulse when a vsync rise is ignored during DRAIN
- pix_x  out  12  pixels accepted so far in current line
- pix_y  out  12  lines completed in current frame
- err_flags  out  2  [0] some line length ≠ IMG_HDISP, [1] line count ≠ IMG_VDISP; valid from frame_done
- frame_cnt  out  8  completed frames, wraps 255→0

## Operation
- vs_d register holds the previous cycle's vsync.
- vs_rise = vsync & ~vs_d; vs_fall = ~vsync & vs_d.
- A pixel is accepted when href & clken are both high while the state is ACTIVE.
- A line end is the falling edge of href (href_d & ~href) in ACTIVE, or vs_fall while href_d=1. A coincident href fall and vs_fall count as one line end.
- States:
  - IDLE: all conv_* low. Go to WAIT when cfg_enable=1.
  - WAIT: conv_* low except in the admission cycle.
    - vs_rise & cfg_enable → ACTIVE. frame_start=1 that cycle; conv_* pass through that same cycle.
    - cfg_enable=0 → IDLE.
    - Enabling while vsync is already high admits nothing until the next rise.
  - ACTIVE: conv_* = per_* (combinational, zero latency). cfg_enable is ignored.
    - vs_fall → DRAIN. The drain counter loads LATENCY−1.
  - DRAIN: conv_* low. The counter decrements each cycle.
    - At 0: frame_done=1, err_flags and frame_cnt update. Next state is WAIT if cfg_enable, else IDLE.
    - A vs_rise during DRAIN pulses frame_drop; that frame is not admitted.
- Counters:
  - pix_x increments on each accepted pixel and saturates at 4095.
  - At a line end, if pix_x ≠ IMG_HDISP, set err_acc[0]. pix_x then clears and pix_y increments, saturating at 4095.
  - At vs_fall, evaluate pix_y, including any line end in the same cycle. If it ≠ IMG_VDISP, set err_acc[1].
  - pix_x, pix_y and err_acc clear at frame_start.
  - err_flags ← err_acc on frame_done and holds until the next frame_done.
- Reset is asynchronous. State goes to IDLE; every register and output clears to 0, so conv_* are immediately low. A frame interrupted by reset is never reported.

## Timing
- Reset values: all outputs 0.
- conv_* carry no added latency versus per_* while admitted.
- frame_start coincides with the first cycle where vsync=1 is passed to the converter.
- frame_done is asserted exactly LATENCY cycles after the cycle in which vs_fall is detected. With LATENCY=3, vs_fall at cycle T gives frame_done at T+3.
- busy rises with frame_start's successor cycle and falls the cycle after frame_done.
- frame_cnt and err_flags change on the cycle frame_done is high.
- Minimum vertical blanking for a back-to-back admit is LATENCY+1 cycles of vsync low. A shorter gap produces frame_drop.

## Test plan
- **Nominal frame:** IMG_HDISP=4, IMG_VDISP=2, enable held high, 2 lines of 4 pixels. Required: frame_start once; conv_* identical to inputs; frame_done at vs_fall+3; err_flags=00; frame_cnt=1.
- **Late enable:** raise cfg_enable mid-frame (vsync high). Required: conv_* stay low for that frame, no frame_start; the next frame is admitted normally.
- **Disable mid-frame:** drop cfg_enable during ACTIVE. Required: the current frame passes completely, frame_done is pulsed, state goes to IDLE, and the next frame's conv_* stay low.
- **Geometry errors:** one line of 3 pixels, then 3 lines total (HDISP=4, VDISP=2). Required: err_flags=11 at frame_done; next good frame gives 00.
- **Short blanking:** vsync low for 2 cycles with LATENCY=3. Required: frame_drop one cycle at the rise; frame_done still at vs_fall+3; the dropped frame is not passed; the following frame is admitted.
- **Reset mid-ACTIVE:** assert rst_n=0 mid-line. Required: all outputs 0 immediately, no frame_done, and after release waits in IDLE.
